// File: rtl/aes_128_sched.sv
// aes_128_sched: two-requester issue arbiter for the pipelined aes_128 core with a credit-gated FWFT result FIFO.
// Optional build macro AES_SCHED_FIXED_PRIO_EN selects strict A-over-B priority instead of round-robin.
`default_nettype none

module aes_128_sched #(
  parameter int LATENCY    = 21,
  parameter int FIFO_DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [127:0] a_state,
  input  logic [127:0] a_key,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [127:0] b_state,
  input  logic [127:0] b_key,
  output logic [127:0] core_state,
  output logic [127:0] core_key,
  input  logic [127:0] core_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_src
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    credits;
  logic             can_issue;
  logic             issue_a;
  logic             issue_b;
  logic             issue;
  logic [LATENCY:0] sr_valid;
  logic [LATENCY:0] sr_src;
  logic             fifo_wr;
  logic             fifo_pop;
  logic             fifo_empty;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [128:0]     mem [FIFO_DEPTH];

  // Every block in the core pipe already owns a FIFO slot, so the core never has to stall.
  assign credits   = CW'(FIFO_DEPTH) - fifo_count - inflight;
  assign can_issue = (credits != '0) && !rst;

`ifdef AES_SCHED_FIXED_PRIO_EN
  assign a_ready = can_issue;
  assign b_ready = can_issue && !a_valid;
`else
  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;
  src_e last;

  assign a_ready = can_issue && (!b_valid || last == SRC_B);
  assign b_ready = can_issue && (!a_valid || last == SRC_A);

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= SRC_B;
    end else if (issue) begin
      last <= issue_b ? SRC_B : SRC_A;
    end
  end
`endif

  assign issue_a = a_valid && a_ready;
  assign issue_b = b_valid && b_ready;
  assign issue   = issue_a || issue_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      core_state <= '0;
      core_key   <= '0;
    end else if (issue_b) begin
      core_state <= b_state;
      core_key   <= b_key;
    end else if (issue_a) begin
      core_state <= a_state;
      core_key   <= a_key;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_valid <= '0;
      sr_src   <= '0;
    end else begin
      sr_valid <= {sr_valid[LATENCY-1:0], issue};
      sr_src   <= {sr_src[LATENCY-1:0], issue_b};
    end
  end

  assign fifo_wr    = sr_valid[LATENCY];
  assign fifo_empty = (fifo_count == '0);
  assign out_valid  = !fifo_empty;
  assign fifo_pop   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_count <= '0;
      inflight   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({fifo_wr, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      case ({issue, fifo_wr})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Storage is left unreset; the head is masked while empty so out_data reads zero.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem[wr_ptr] <= {sr_src[LATENCY], core_out};
    end
  end

  assign out_data = fifo_empty ? '0 : mem[rd_ptr][127:0];
  assign out_src  = !fifo_empty && mem[rd_ptr][128];

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (({1'b0, fifo_count} + {1'b0, inflight}) <= (CW + 1)'(FIFO_DEPTH));
      assert (!(fifo_wr && fifo_count == CW'(FIFO_DEPTH)));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_128_sched.sv
// Scoreboard bench for aes_128_sched with a behavioural stand-in for the aes_128 pipeline.
`default_nettype none

module tb_aes_128_sched;

  localparam int LATENCY    = 21;
  localparam int FIFO_DEPTH = 32;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid, a_ready, b_valid, b_ready;
  logic [127:0] a_state, a_key, b_state, b_key;
  logic [127:0] core_state, core_key, core_out;
  logic         out_valid, out_ready, out_src;
  logic [127:0] out_data;

  always #5 clk = ~clk;

  aes_128_sched #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_state(a_state), .a_key(a_key),
    .b_valid(b_valid), .b_ready(b_ready), .b_state(b_state), .b_key(b_key),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src)
  );

  // Stand-in core: known FIPS-197 answer for the C.1 vector, state^key otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] s, input logic [127:0] k);
    if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return s ^ k;
  endfunction

  logic [127:0] core_pipe [LATENCY];
  always @(posedge clk) begin
    core_pipe[0] <= core_fn(core_state, core_key);
    for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[LATENCY-1];

  typedef struct packed { logic [127:0] st; logic [127:0] ky; } req_t;
  typedef struct packed { logic [127:0] data; logic src; } exp_t;

  req_t qa[$];
  req_t qb[$];
  exp_t sb[$];
  logic grants[$];
  int   pop_cyc[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accepts = 0;
  int   mode = 1;
  logic rst_req = 1'b1;
  logic s_ar, s_br, s_ov;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  function automatic req_t mk(input logic [7:0] tag, input int i);
    req_t r;
    r.st = {tag, 24'(i), 96'h0123_4567_89ab_cdef_0011_2233};
    r.ky = {96'hfeed_0000_beef_1111_2222_3333, 32'(i * 7 + 1)};
    return r;
  endfunction

  // One clock: drive at negedge, sample readies, account transfers at the posedge.
  task automatic step();
    logic ta, tb;
    exp_t e;
    @(negedge clk);
    rst     = rst_req;
    a_valid = (qa.size() > 0);
    b_valid = (qb.size() > 0);
    if (a_valid) begin a_state = qa[0].st; a_key = qa[0].ky; end
    if (b_valid) begin b_state = qb[0].st; b_key = qb[0].ky; end
    case (mode)
      0:       out_ready = 1'b0;
      2:       out_ready = cyc[0];
      default: out_ready = 1'b1;
    endcase
    #1;
    s_ar = a_ready;
    s_br = b_ready;
    s_ov = out_valid;
    ta   = a_valid && a_ready;
    tb   = b_valid && b_ready;
    @(posedge clk);
    if (ta && tb) chk("double_grant", 1, 0);
    if (ta) begin
      e.data = core_fn(qa[0].st, qa[0].ky); e.src = 1'b0;
      sb.push_back(e); void'(qa.pop_front()); grants.push_back(1'b0); accepts++;
    end
    if (tb) begin
      e.data = core_fn(qb[0].st, qb[0].ky); e.src = 1'b1;
      sb.push_back(e); void'(qb.pop_front()); grants.push_back(1'b1); accepts++;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && (sb.size() > 0 || qa.size() > 0 || qb.size() > 0); i++) step();
    chk(name, sb.size() + qa.size() + qb.size(), 0);
  endtask

  // Monitor: every pop is compared against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result got data=%h src=%0d required no output", out_data, out_src);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_src !== e.src) begin
            errors++;
            $display("FAIL result got data=%h src=%0d required data=%h src=%0d",
                     out_data, out_src, e.data, e.src);
          end
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    int lat;
    int bad;
    int cnt;
    req_t r;
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    a_state = '0; a_key = '0; b_state = '0; b_key = '0;

    // Reset state, with A already requesting.
    r.st = FIPS_PT; r.ky = FIPS_KEY;
    qa.push_back(r);
    rst_req = 1'b1; mode = 1;
    step(); step();
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_core_state", core_state, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_credits", dut.credits, FIFO_DEPTH);

    // FIPS-197 C.1 on A: accept, then first out_valid LATENCY+2 cycles later.
    rst_req = 1'b0;
    accepts = 0;
    for (int i = 0; i < 5 && accepts == 0; i++) step();
    chk("fips_accept", accepts, 1);
    lat = 0;
    for (int i = 1; i <= LATENCY + 10 && lat == 0; i++) begin
      step();
      if (s_ov) lat = i;
    end
    chk("fips_latency", lat, LATENCY + 2);
    drain("fips_drain");

    // Both requesters streaming 8 blocks each from a fresh reset.
    rst_req = 1'b1; step(); rst_req = 1'b0;
    grants.delete(); pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      qa.push_back(mk(8'hA0, i));
      qb.push_back(mk(8'hB0, i));
    end
    drain("arb_drain");
    bad = 0;
    for (int i = 0; i < grants.size(); i++) begin
`ifdef AES_SCHED_FIXED_PRIO_EN
      if (grants[i] !== (i >= 8)) bad++;
`else
      if (grants[i] !== i[0]) bad++;
`endif
    end
    chk("arb_grant_count", grants.size(), 16);
    chk("arb_grant_order_errs", bad, 0);
    chk("arb_results", pop_cyc.size(), 16);
    if (pop_cyc.size() == 16) chk("arb_consecutive", pop_cyc[15] - pop_cyc[0], 15);

    // Back-pressure: exactly FIFO_DEPTH accepts, then one more per pop.
    mode = 0; accepts = 0;
    for (int i = 0; i < 40; i++) qa.push_back(mk(8'hC0, i));
    for (int i = 0; i < 60; i++) step();
    chk("full_accepts", accepts, FIFO_DEPTH);
    chk("full_a_ready", s_ar, 0);
    mode = 1; step();
    mode = 0;
    for (int i = 0; i < 6; i++) step();
    chk("full_one_more", accepts, FIFO_DEPTH + 1);
    chk("full_a_ready_again", s_ar, 0);
    mode = 1;
    drain("full_drain");

    // Toggling out_ready while both stream: writes and pops collide at zero credit.
    mode = 2;
    for (int i = 0; i < 24; i++) begin
      qa.push_back(mk(8'hD0, i));
      qb.push_back(mk(8'hE0, i));
    end
    drain("toggle_drain");

    // Reset with three blocks in flight: they must never emerge.
    mode = 1; accepts = 0;
    for (int i = 0; i < 3; i++) qa.push_back(mk(8'hF0, i));
    for (int i = 0; i < 10 && accepts < 3; i++) step();
    chk("midrst_accepts", accepts, 3);
    for (int i = 0; i < 5; i++) step();
    rst_req = 1'b1; step(); rst_req = 1'b0;
    sb.delete();
    cnt = 0;
    for (int i = 0; i < LATENCY + 8; i++) begin
      step();
      if (s_ov) cnt++;
    end
    chk("midrst_no_output", cnt, 0);
    #1;
    chk("midrst_credits", dut.credits, FIFO_DEPTH);
    qb.push_back(mk(8'h5B, 1));
    drain("midrst_fresh");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
